ws_pe_mac: RTL and testbench
============================

# ws_pe_mac

Weight-stationary processing element for the systolic array. Holds one stationary weight, multiplies each incoming activation by it, and adds the product to the partial sum arriving from the PE above. It forwards the activation right and the updated partial sum down. It sits directly downstream of the unsigned add-shift multiplier, consumes its 2*D_W product every cycle, and provides a per-PE fault-injection point on the partial-sum register.

## Interface
Parameters:
- D_W, 8, activation/weight width (unsigned)
- ACC_W, 32, partial-sum width; must satisfy ACC_W >= 2*D_W

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- w_load  in  1  load/shift weight chain this cycle
- w_in  in  D_W  weight from PE above (or array edge)
- w_out  out  D_W  registered weight to PE below
- a_in  in  D_W  activation from PE to the left
- a_valid_in  in  1  a_in valid
- a_out  out  D_W  registered activation to PE to the right
- a_valid_out  out  1  registered a_valid_in
- psum_in  in  ACC_W  partial sum from PE above
- psum_out  out  ACC_W  registered partial sum to PE below
- psum_valid_out  out  1  psum_out updated last edge
- fi_en  in  1  fault-injection enable
- fi_mask  in  ACC_W  XOR mask applied to psum on injection
- ovf  out  1  sticky accumulate-overflow flag
- ovf_clr  in  1  clears ovf

## Operation
- Weight FSM, 2 states: W_EMPTY (reset) -> W_LOADED on any cycle with w_load=1. W_LOADED stays W_LOADED (w_load re-loads). Only rst returns to W_EMPTY.
- w_load=1: weight_reg <= w_in. w_out is always weight_reg, so a column of PEs shifts weights one PE per cycle.
- MAC on a_valid_in=1: psum_out <= (psum_in + zext(product)) mod 2^ACC_W, where product = a_in * weight_reg is unsigned and 2*D_W wide.
- In W_EMPTY, product is forced to 0, so psum_in passes through unchanged.
- a_valid_in=0: psum_out holds its value and psum_valid_out <= 0. a_out/a_valid_out still register a_in/a_valid_in.
- Overflow: carry out of the ACC_W-bit add on a valid cycle sets ovf. ovf_clr=1 clears it. If set and clear occur in the same cycle, set wins.
- Fault injection: fi_en=1 on a valid cycle gives psum_out <= sum XOR fi_mask. fi_en is ignored on invalid cycles. ovf is computed on the un-faulted sum.
- w_load and a_valid_in in the same cycle: the MAC uses the pre-load weight_reg and pre-load FSM state. The new weight takes effect from the next cycle.

## Timing
- Reset values: w_out=0, a_out=0, a_valid_out=0, psum_out=0, psum_valid_out=0, ovf=0, FSM=W_EMPTY, weight_reg=0.
- Latency: 1 cycle for each of a_in->a_out, psum_in->psum_out, and w_in->w_out.
- No back-pressure; every valid input is consumed on the edge it is presented.
- rst asserted mid-stream: all outputs reach reset values at the next edge, overriding w_load, a_valid_in and fi_en in that cycle.
- Multiplier path is combinational inside the cycle (weight_reg x a_in -> adder -> psum register). Timing closure is owned by the multiplier instance.

## Structure
- Shared package (systolic_pkg): default D_W/ACC_W constants and the weight-state enum (W_EMPTY, W_LOADED).
- One sub-module: add_shift_multiplier_simple (D_W), instantiated once with a=a_in, b=weight_reg.
- All remaining logic is local: FSM, registers, adder, overflow, and fault XOR.

## Test plan
- Reset then a_valid_in=1, a_in=5, psum_in=100 with no load -> psum_out=100 next cycle (W_EMPTY passthrough), psum_valid_out=1.
- w_load=1, w_in=7; next cycle a_in=9, psum_in=10, valid -> psum_out=73, a_out=9, w_out=7.
- Same-cycle w_load (w_in=3) with old weight 7, a_in=2, psum_in=0 -> psum_out=14. Following cycle a_in=2 -> psum_out=6.
- ACC_W=16, weight=255, a_in=255, psum_in=0xFFFF -> psum_out=0xFE00, ovf=1. ovf stays 1 until ovf_clr. ovf_clr concurrent with a new overflow -> ovf stays 1.
- fi_en=1, fi_mask=0x1 with weight=2, a_in=3, psum_in=0 -> psum_out=7. Same stimulus with a_valid_in=0 -> psum_out holds, psum_valid_out=0.
- rst pulsed between two valid MACs -> all outputs 0 next edge. The following MAC passes psum_in through (W_EMPTY).

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared constants and weight-state encoding for the systolic-array PEs.
package systolic_pkg;
  localparam int D_W_DEF   = 8;
  localparam int ACC_W_DEF = 32;

  typedef enum logic {
    W_EMPTY  = 1'b0,
    W_LOADED = 1'b1
  } w_state_e;
endpackage

// File: rtl/ws_pe_mac_if.sv
// Dataflow bundle of a weight-stationary PE: weight chain, activation, partial sum, fault/ovf control.
interface ws_pe_mac_if
  import systolic_pkg::*;
#(
  parameter int D_W   = D_W_DEF,
  parameter int ACC_W = ACC_W_DEF
);
  logic             w_load;
  logic [D_W-1:0]   w_in;
  logic [D_W-1:0]   w_out;
  logic [D_W-1:0]   a_in;
  logic             a_valid_in;
  logic [D_W-1:0]   a_out;
  logic             a_valid_out;
  logic [ACC_W-1:0] psum_in;
  logic [ACC_W-1:0] psum_out;
  logic             psum_valid_out;
  logic             fi_en;
  logic [ACC_W-1:0] fi_mask;
  logic             ovf;
  logic             ovf_clr;

  modport master (
    output w_load, w_in, a_in, a_valid_in, psum_in, fi_en, fi_mask, ovf_clr,
    input  w_out, a_out, a_valid_out, psum_out, psum_valid_out, ovf
  );

  modport slave (
    input  w_load, w_in, a_in, a_valid_in, psum_in, fi_en, fi_mask, ovf_clr,
    output w_out, a_out, a_valid_out, psum_out, psum_valid_out, ovf
  );
endinterface

// File: rtl/add_shift_multiplier_simple.sv
// Unsigned combinational add-shift multiplier: p = a * b, full 2*D_W width.
module add_shift_multiplier_simple #(
  parameter int D_W = 8
) (
  input  logic [D_W-1:0]   a,
  input  logic [D_W-1:0]   b,
  output logic [2*D_W-1:0] p
);
  logic [2*D_W-1:0] a_ext;

  assign a_ext = {{D_W{1'b0}}, a};

  always_comb begin
    p = '0;
    for (int i = 0; i < D_W; i++)
      if (b[i]) p = p + (a_ext << i);
  end
endmodule

// File: rtl/ws_pe_mac.sv
// Weight-stationary PE: psum_out <= psum_in + a_in*weight, with sticky overflow and psum fault XOR.
module ws_pe_mac
  import systolic_pkg::*;
#(
  parameter int D_W   = D_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input logic        clk,
  input logic        rst,
  ws_pe_mac_if.slave pe
);
  w_state_e           w_state;
  logic [D_W-1:0]     weight_reg;
  logic [2*D_W-1:0]   prod;
  logic [2*D_W-1:0]   prod_eff;
  logic [ACC_W:0]     sum_full;
  logic [ACC_W-1:0]   sum;
  logic               carry;

  add_shift_multiplier_simple #(.D_W(D_W)) u_mul (
    .a (pe.a_in),
    .b (weight_reg),
    .p (prod)
  );

  // An unloaded PE must be transparent to the column, whatever stale weight it holds.
  assign prod_eff = (w_state == W_LOADED) ? prod : '0;
  assign sum_full = {1'b0, pe.psum_in} + (ACC_W+1)'(prod_eff);
  assign sum      = sum_full[ACC_W-1:0];
  assign carry    = sum_full[ACC_W];

  assign pe.w_out = weight_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state           <= W_EMPTY;
      weight_reg        <= '0;
      pe.a_out          <= '0;
      pe.a_valid_out    <= 1'b0;
      pe.psum_out       <= '0;
      pe.psum_valid_out <= 1'b0;
      pe.ovf            <= 1'b0;
    end else begin
      // Load takes effect next cycle; this cycle's MAC sees the old weight and state.
      if (pe.w_load) begin
        weight_reg <= pe.w_in;
        w_state    <= W_LOADED;
      end
      pe.a_out          <= pe.a_in;
      pe.a_valid_out    <= pe.a_valid_in;
      pe.psum_valid_out <= pe.a_valid_in;
      if (pe.a_valid_in)
        pe.psum_out <= pe.fi_en ? (sum ^ pe.fi_mask) : sum;
      // Overflow tracks the true sum; a set in the same cycle beats a clear.
      if (pe.a_valid_in && carry) pe.ovf <= 1'b1;
      else if (pe.ovf_clr)        pe.ovf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ws_pe_mac.sv
// Directed scoreboard bench for ws_pe_mac at D_W=8, ACC_W=16.
module tb_ws_pe_mac;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ws_pe_mac_if #(.D_W(8), .ACC_W(16)) bus ();

  ws_pe_mac #(.D_W(8), .ACC_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .pe  (bus)
  );

  typedef struct {
    string       tag;
    logic [7:0]  w;
    logic [7:0]  a;
    logic        av;
    logic [15:0] psum;
    logic        pv;
    logic        ovf;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input string fld, input logic [15:0] obs, input logic [15:0] e);
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, e);
    end
  endtask

  // Drive one cycle of stimulus, push its expected outputs, then compare after the edge.
  task automatic step(input string tag, input logic r, input logic wl, input logic [7:0] wi,
                      input logic [7:0] ai, input logic av, input logic [15:0] pi,
                      input logic fe, input logic [15:0] fm, input logic oc,
                      input logic [7:0] ew, input logic [7:0] ea, input logic eav,
                      input logic [15:0] eps, input logic epv, input logic eovf);
    exp_t e;
    exp_t got;
    rst            = r;
    bus.w_load     = wl;
    bus.w_in       = wi;
    bus.a_in       = ai;
    bus.a_valid_in = av;
    bus.psum_in    = pi;
    bus.fi_en      = fe;
    bus.fi_mask    = fm;
    bus.ovf_clr    = oc;
    e.tag = tag; e.w = ew; e.a = ea; e.av = eav; e.psum = eps; e.pv = epv; e.ovf = eovf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk(got.tag, "w_out",          {8'h0, bus.w_out},           {8'h0, got.w});
    chk(got.tag, "a_out",          {8'h0, bus.a_out},           {8'h0, got.a});
    chk(got.tag, "a_valid_out",    {15'h0, bus.a_valid_out},    {15'h0, got.av});
    chk(got.tag, "psum_out",       bus.psum_out,                got.psum);
    chk(got.tag, "psum_valid_out", {15'h0, bus.psum_valid_out}, {15'h0, got.pv});
    chk(got.tag, "ovf",            {15'h0, bus.ovf},            {15'h0, got.ovf});
  endtask

  initial begin
    #1;
    //    tag        rst wl wi     a_in   av pi        fe fm        oc | w      a      av psum      pv ovf
    step("rst0",     1, 1, 8'd9, 8'd5,   1, 16'd77,   1, 16'hFFFF, 0,  8'd0,  8'd0,  0, 16'd0,    0, 0);
    step("rst1",     1, 0, 8'd0, 8'd0,   0, 16'd0,    0, 16'h0,    0,  8'd0,  8'd0,  0, 16'd0,    0, 0);
    step("empty",    0, 0, 8'd0, 8'd5,   1, 16'd100,  0, 16'h0,    0,  8'd0,  8'd5,  1, 16'd100,  1, 0);
    step("load7",    0, 1, 8'd7, 8'd0,   0, 16'd0,    0, 16'h0,    0,  8'd7,  8'd0,  0, 16'd100,  0, 0);
    step("mac73",    0, 0, 8'd0, 8'd9,   1, 16'd10,   0, 16'h0,    0,  8'd7,  8'd9,  1, 16'd73,   1, 0);
    step("ldmac14",  0, 1, 8'd3, 8'd2,   1, 16'd0,    0, 16'h0,    0,  8'd3,  8'd2,  1, 16'd14,   1, 0);
    step("mac6",     0, 0, 8'd0, 8'd2,   1, 16'd0,    0, 16'h0,    0,  8'd3,  8'd2,  1, 16'd6,    1, 0);
    step("load255",  0, 1, 8'hFF,8'd0,   0, 16'd0,    0, 16'h0,    0,  8'hFF, 8'd0,  0, 16'd6,    0, 0);
    step("ovf_set",  0, 0, 8'd0, 8'hFF,  1, 16'hFFFF, 0, 16'h0,    0,  8'hFF, 8'hFF, 1, 16'hFE00, 1, 1);
    step("ovf_hold", 0, 0, 8'd0, 8'd0,   1, 16'd5,    0, 16'h0,    0,  8'hFF, 8'd0,  1, 16'd5,    1, 1);
    step("ovf_clr",  0, 0, 8'd0, 8'd0,   0, 16'd0,    0, 16'h0,    1,  8'hFF, 8'd0,  0, 16'd5,    0, 0);
    step("ovf_set2", 0, 0, 8'd0, 8'hFF,  1, 16'hFFFF, 0, 16'h0,    0,  8'hFF, 8'hFF, 1, 16'hFE00, 1, 1);
    step("set_win",  0, 0, 8'd0, 8'hFF,  1, 16'hFFFF, 0, 16'h0,    1,  8'hFF, 8'hFF, 1, 16'hFE00, 1, 1);
    step("ovf_clr2", 0, 0, 8'd0, 8'd0,   0, 16'd0,    0, 16'h0,    1,  8'hFF, 8'd0,  0, 16'hFE00, 0, 0);
    step("max_nocy", 0, 1, 8'd2, 8'd1,   1, 16'hFF00, 0, 16'h0,    0,  8'd2,  8'd1,  1, 16'hFFFF, 1, 0);
    step("fi7",      0, 0, 8'd0, 8'd3,   1, 16'd0,    1, 16'h0001, 0,  8'd2,  8'd3,  1, 16'd7,    1, 0);
    step("fi_inval", 0, 0, 8'd0, 8'd3,   0, 16'd0,    1, 16'h0001, 0,  8'd2,  8'd3,  0, 16'd7,    0, 0);
    step("fi_noovf", 0, 0, 8'd0, 8'd0,   1, 16'hFFFF, 1, 16'hFFFF, 0,  8'd2,  8'd0,  1, 16'h0000, 1, 0);
    step("fi_ovf",   0, 0, 8'd0, 8'd3,   1, 16'hFFFE, 1, 16'h00FF, 0,  8'd2,  8'd3,  1, 16'h00FB, 1, 1);
    step("clr3",     0, 0, 8'd0, 8'd0,   0, 16'd0,    0, 16'h0,    1,  8'd2,  8'd0,  0, 16'h00FB, 0, 0);
    step("pre_rst",  0, 0, 8'd0, 8'd3,   1, 16'd100,  0, 16'h0,    0,  8'd2,  8'd3,  1, 16'd106,  1, 0);
    step("mid_rst",  1, 1, 8'd9, 8'd4,   1, 16'd50,   1, 16'hFFFF, 0,  8'd0,  8'd0,  0, 16'd0,    0, 0);
    step("post_rst", 0, 0, 8'd0, 8'd4,   1, 16'd50,   0, 16'h0,    0,  8'd0,  8'd4,  1, 16'd50,   1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
